// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the execute stage.
//   - ALU operation codes (alu_op)
//   - bit positions inside the 8-bit control bundle
//   - multiply/divide FSM state encoding
//   - registered output bundle of the stage
package mips_pkg;

  localparam int DW = 32;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOR   = 4'h5;
  localparam logic [3:0] OP_SLT   = 4'h6;
  localparam logic [3:0] OP_SLTU  = 4'h7;
  localparam logic [3:0] OP_SLL   = 4'h8;
  localparam logic [3:0] OP_SRL   = 4'h9;
  localparam logic [3:0] OP_SRA   = 4'hA;
  localparam logic [3:0] OP_MULTU = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_MFHI  = 4'hD;
  localparam logic [3:0] OP_MFLO  = 4'hE;
  localparam logic [3:0] OP_LUI   = 4'hF;

  localparam int SIG_ALUSRC   = 7;
  localparam int SIG_MEMTOREG = 6;
  localparam int SIG_REGWRITE = 5;
  localparam int SIG_MEMREAD  = 4;
  localparam int SIG_MEMWRITE = 3;
  localparam int SIG_BRANCH   = 2;
  localparam int SIG_EQ       = 1;
  localparam int SIG_GOTO     = 0;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} md_state_e;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] valb;
    logic [7:0]    signals;
    logic          br_taken;
    logic [DW-1:0] br_target;
  } ex_out_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: decode -> execute request and execute -> memory result.
//   master (decode/bench): drives in_valid, valA, valB, imm, pc_plus4,
//                          alu_op, signals; sees in_ready and the results.
//   slave  (execute_stage): the reverse.
interface execute_stage_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc_plus4;
  logic [3:0]       alu_op;
  logic [7:0]       signals;
  logic             out_valid;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] valB_out;
  logic [7:0]       signals_out;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;

  modport master (
    output in_valid, valA, valB, imm, pc_plus4, alu_op, signals,
    input  in_ready, out_valid, alu_result, valB_out, signals_out,
           branch_taken, branch_target
  );

  modport slave (
    input  in_valid, valA, valB, imm, pc_plus4, alu_op, signals,
    output in_ready, out_valid, alu_result, valB_out, signals_out,
           branch_taken, branch_target
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply / restoring divide, 32 steps.
// Ports:
//   clock, reset   clock, synchronous active-low reset (aborts any op)
//   start          launch an op (only honoured in IDLE)
//   op             0 = MULTU, 1 = DIVU
//   a, b           operands (a*b, or a/b)
//   busy           FSM not in IDLE
//   done           high during the final iteration cycle; HI/LO load at its edge
//   hi, lo         result registers
module muldiv_unit
  import mips_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  // work holds {upper, multiplier} for MULTU and {remainder, quotient} for
  // DIVU, so HI/LO come from the same halves in both cases.
  logic [2*DW-1:0] work_q, work_d;
  logic [DW-1:0]   opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] mul_next, div_next;
  logic [DW:0]     div_r, div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum  = {1'b0, work_q[2*DW-1:DW]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, work_q[DW-1:1]};
    // Divisor 0 always "fits": quotient becomes all ones and the dividend
    // bits shift unchanged into the remainder, i.e. LO=FFFFFFFF, HI=A.
    div_r    = {work_q[2*DW-1:DW], work_q[DW-1]};
    div_diff = div_r - {1'b0, opnd_q};
    div_ge   = (div_r >= {1'b0, opnd_q});
    div_next = {(div_ge ? div_diff[DW-1:0] : div_r[DW-1:0]),
                work_q[DW-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = op ? DIV : MUL;
          cnt_d   = '0;
          work_d  = {{DW{1'b0}}, (op ? a : b)};
          opnd_d  = op ? b : a;
        end
      end
      MUL, DIV: begin
        work_d = (state_q == MUL) ? mul_next : div_next;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          done    = 1'b1;
          state_d = IDLE;
          hi_d    = work_d[2*DW-1:DW];
          lo_d    = work_d[DW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/execute_stage.sv
// execute_stage: registered MIPS execute stage.
// Ports:
//   clock, reset  clock, synchronous active-low reset
//   bus (slave)   decode request (in_valid/in_ready, operands, alu_op,
//                 signals) and registered results to the memory stage
//                 (out_valid, alu_result, valB_out, signals_out,
//                 branch_taken, branch_target)
// Single-cycle ops register at the accept edge. MULTU/DIVU park their
// output bundle and release it on the edge the unit writes HI/LO.
module execute_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  execute_stage_if.slave bus
);

  logic             accept, is_md, md_busy, md_done;
  logic [WIDTH-1:0] op_a, op_b, alu_res, hi, lo;
  logic [4:0]       shamt;
  ex_out_t          cur, out_d, out_q, pend_q;

  assign op_a   = bus.valA;
  assign op_b   = bus.signals[SIG_ALUSRC] ? bus.imm : bus.valB;
  assign shamt  = op_b[4:0];
  assign accept = bus.in_valid & bus.in_ready;
  assign is_md  = is_muldiv(bus.alu_op);

  muldiv_unit u_md (
    .clock (clock),
    .reset (reset),
    .start (accept & is_md),
    .op    (bus.alu_op == OP_DIVU),
    .a     (op_a),
    .b     (op_b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    alu_res = '0;
    unique case (bus.alu_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      OP_LUI:  alu_res = {op_b[15:0], 16'h0};
      default: alu_res = '0;   // MULTU/DIVU report 0
    endcase
  end

  always_comb begin
    cur.valid      = 1'b1;
    cur.alu_result = alu_res;
    cur.valb       = bus.valB;
    cur.signals    = bus.signals;
    cur.br_taken   = bus.signals[SIG_BRANCH] &
                     (bus.signals[SIG_EQ] ? (bus.valA == bus.valB)
                                          : (bus.valA != bus.valB));
    cur.br_target  = bus.pc_plus4 + {bus.imm[WIDTH-3:0], 2'b00};

    // Anything other than a fresh single-cycle op or a finishing
    // multiply/divide registers an all-zero bubble.
    out_d = '0;
    if (md_done)              out_d = pend_q;
    else if (accept && !is_md) out_d = cur;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_q  <= '0;
      pend_q <= '0;
    end else begin
      out_q <= out_d;
      if (accept && is_md) pend_q <= cur;
    end
  end

  assign bus.in_ready      = ~md_busy;
  assign bus.out_valid     = out_q.valid;
  assign bus.alu_result    = out_q.alu_result;
  assign bus.valB_out      = out_q.valb;
  assign bus.signals_out   = out_q.signals;
  assign bus.branch_taken  = out_q.br_taken;
  assign bus.branch_target = out_q.br_target;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expected values.
module tb_execute_stage;
  import mips_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  execute_stage_if #(.WIDTH(32)) bus ();

  execute_stage #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single edge; returns #1 after that edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] sig,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] pc);
    @(negedge clock);
    bus.alu_op   = op;
    bus.signals  = sig;
    bus.valA     = a;
    bus.valB     = b;
    bus.imm      = im;
    bus.pc_plus4 = pc;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Run a MULTU/DIVU and check its stall length, bubbles and completion.
  task automatic run_md(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int stall = 0;
    int bubbles_bad = 0;
    issue(op, 8'h40, a, b, 32'h0, 32'h0);
    while (!bus.in_ready && stall < 100) begin
      stall++;
      if (bus.out_valid !== 1'b0 || bus.signals_out !== 8'h0) bubbles_bad++;
      @(posedge clock);
      #1;
    end
    chk({tag, "_stall"}, stall, 32);
    chk({tag, "_bubbles"}, bubbles_bad, 0);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_res0"}, bus.alu_result, 0);
    chk({tag, "_sig"}, bus.signals_out, 8'h40);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.alu_op   = '0;
    bus.signals  = '0;
    bus.valA     = '0;
    bus.valB     = '0;
    bus.imm      = '0;
    bus.pc_plus4 = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_res", bus.alu_result, 0);
    chk("rst_sig", bus.signals_out, 0);
    chk("rst_ready", bus.in_ready, 1);
    @(negedge clock);
    reset = 1'b1;

    // ADD with immediate: 5 + (-3)
    issue(OP_ADD, 8'hA0, 32'd5, 32'h77, 32'hFFFF_FFFD, 32'h0);
    chk("add_res", bus.alu_result, 2);
    chk("add_valid", bus.out_valid, 1);
    chk("add_sig", bus.signals_out, 8'hA0);
    chk("add_valb", bus.valB_out, 32'h77);
    @(posedge clock);
    #1;
    chk("bubble_valid", bus.out_valid, 0);
    chk("bubble_sig", bus.signals_out, 0);

    issue(OP_SLT, 8'h20, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    chk("slt", bus.alu_result, 1);
    issue(OP_SLTU, 8'h20, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    chk("sltu", bus.alu_result, 0);
    issue(OP_SRA, 8'hA0, 32'h8000_0000, 32'h0, 32'd4, 32'h0);
    chk("sra", bus.alu_result, 32'hF800_0000);
    issue(OP_SRL, 8'hA0, 32'h8000_0000, 32'h0, 32'd4, 32'h0);
    chk("srl", bus.alu_result, 32'h0800_0000);
    issue(OP_SUB, 8'h20, 32'd3, 32'd5, 32'h0, 32'h0);
    chk("sub", bus.alu_result, 32'hFFFF_FFFE);
    issue(OP_NOR, 8'h20, 32'h0F0F_0000, 32'h0000_00FF, 32'h0, 32'h0);
    chk("nor", bus.alu_result, 32'hF0F0_FF00);
    issue(OP_LUI, 8'hA0, 32'h0, 32'h0, 32'h0000_1234, 32'h0);
    chk("lui", bus.alu_result, 32'h1234_0000);

    run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    issue(OP_MFHI, 8'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("mul_hi", bus.alu_result, 1);
    chk("mfhi_valid", bus.out_valid, 1);
    issue(OP_MFLO, 8'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("mul_lo", bus.alu_result, 32'hFFFF_FFFE);

    run_md("divu", OP_DIVU, 32'd100, 32'd7);
    issue(OP_MFLO, 8'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("div_lo", bus.alu_result, 14);
    issue(OP_MFHI, 8'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("div_hi", bus.alu_result, 2);

    run_md("div0", OP_DIVU, 32'd9, 32'd0);
    issue(OP_MFLO, 8'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("div0_lo", bus.alu_result, 32'hFFFF_FFFF);
    issue(OP_MFHI, 8'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("div0_hi", bus.alu_result, 9);

    // Branches: BEQ equal / unequal, BNE unequal
    issue(OP_SUB, 8'h06, 32'd3, 32'd3, 32'd4, 32'h100);
    chk("beq_taken", bus.branch_taken, 1);
    chk("beq_target", bus.branch_target, 32'h110);
    issue(OP_SUB, 8'h06, 32'd3, 32'd4, 32'd4, 32'h100);
    chk("beq_not", bus.branch_taken, 0);
    issue(OP_SUB, 8'h04, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'h100);
    chk("bne_taken", bus.branch_taken, 1);
    chk("bne_target", bus.branch_target, 32'hFC);
    @(posedge clock);
    #1;
    chk("bubble_br", bus.branch_taken, 0);

    // Reset in the middle of a DIVU (edge sampling reset is iteration 10)
    issue(OP_DIVU, 8'h40, 32'd1000, 32'd3, 32'h0, 32'h0);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mrst_ready", bus.in_ready, 1);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_res", bus.alu_result, 0);
    chk("mrst_sig", bus.signals_out, 0);
    chk("mrst_br", {bus.branch_taken, bus.branch_target}, 0);
    @(negedge clock);
    reset = 1'b1;
    issue(OP_MFHI, 8'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("mrst_hi", bus.alu_result, 0);
    issue(OP_MFLO, 8'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("mrst_lo", bus.alu_result, 0);
    issue(OP_ADD, 8'h20, 32'd7, 32'd8, 32'h0, 32'h0);
    chk("post_add", bus.alu_result, 15);
    chk("post_valid", bus.out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Registered execute stage of the MIPS pipeline. It sits directly upstream of the memory stage and produces the `alu_result`, `valB` and `signals` values that stage consumes. Single-cycle ALU operations complete in one clock. Unsigned multiply and divide run on an iterative 32-cycle unit that writes HI/LO and stalls issue while busy. Branch resolution is also done here.

## Interface
- `WIDTH`, default 32: datapath width. Only 32 is supported.
- `clock` input 1: single clock, rising-edge.
- `reset` input 1: synchronous, active-low.
- `in_valid` input 1: decode presents an instruction this cycle.
- `in_ready` output 1: high when the stage can accept. Low while multiply/divide is busy.
- `valA` input 32: rs operand.
- `valB` input 32: rt operand.
- `imm` input 32: sign-extended immediate.
- `pc_plus4` input 32: address of the next sequential instruction.
- `alu_op` input 4: operation code, encoded in `mips_pkg`.
- `signals` input 8: control bundle. [7] ALUSrc, [6] MemToReg, [5] reg_write, [4] MemRead, [3] MemWrite, [2] branch, [1] eq, [0] goto_flg.
- `out_valid` output 1: registered outputs hold a real instruction. Low means bubble.
- `alu_result` output 32: registered ALU result; also the memory address.
- `valB_out` output 32: registered rt value, used as store data.
- `signals_out` output 8: registered control bundle.
- `branch_taken` output 1: registered branch decision.
- `branch_target` output 32: registered `pc_plus4 + (imm << 2)`.

## Operation
- Operand B is `imm` if `signals[7]` is set, else `valB`.
- `alu_op` encodings:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU. Result is 32'd1 or 32'd0.
  - 8 SLL, 9 SRL, A SRA. Shift amount is B[4:0]; A is shifted.
  - B MULTU, C DIVU, D MFHI, E MFLO, F LUI. LUI result is `{B[15:0],16'h0}`.
- Arithmetic wraps modulo 2^32. No overflow trap.
- Branch: `branch_taken = signals[2] & (signals[1] ? (valA==valB) : (valA!=valB))`. `branch_target` is always computed.
- State machine `IDLE`, `MUL`, `DIV`:
  - `IDLE` plus accept of MULTU goes to `MUL`; accept of DIVU goes to `DIV`.
  - 32 iterations, one per clock, counted by a 5-bit counter. After the final iteration the FSM returns to `IDLE`.
- MULTU: shift-add, giving `{HI,LO} = A*B`.
- DIVU: restoring division, giving `LO = A/B`, `HI = A%B`.
- Divide by zero: `LO = 32'hFFFFFFFF`, `HI = A`. No exception.
- For MULTU/DIVU, `alu_result` = 0 and `signals_out` passes through unchanged. Decode is responsible for clearing reg_write.
- No accept in a cycle: the next edge registers a bubble. `out_valid` = 0 and `signals_out` = 0, so the memory stage neither reads nor writes. `branch_taken` = 0.
- Reset (`reset`==0 at an edge):
  - FSM goes to `IDLE`, counter 0, HI = LO = 0.
  - All registered outputs 0. `in_ready` = 1 the following cycle.
  - A multiply/divide in progress is aborted and HI/LO are not updated.

## Timing
- Accept happens on a rising edge where `in_valid & in_ready`.
- Single-cycle op accepted at edge E0: outputs valid with `out_valid`=1 immediately after E0. Latency is 1.
- MULTU/DIVU accepted at edge E0:
  - `in_ready` drops after E0.
  - Iterations run at E1..E32. HI/LO are written and the instruction's outputs registered at E32.
  - `out_valid`=1 after E32, and `in_ready` rises after E32.
  - Between E0 and E32 the outputs are bubbles.
- MFHI/MFLO immediately after MULTU/DIVU read the final HI/LO, because issue is serialised by `in_ready`.
- `in_ready` is combinational from the FSM state: high iff `IDLE`.
- There is no downstream backpressure.
- `in_valid` while `in_ready`=0 is ignored. Decode must hold the instruction.

## Structure
- `mips_pkg` holds:
  - `alu_op` localparams.
  - Signal bit indices: `SIG_ALUSRC`..`SIG_GOTO`.
  - FSM state encoding.
- Sub-module `muldiv_unit` contains the iterative multiply/divide, HI/LO, the counter and the FSM, with ports `start`, `op`, `a`, `b`, `busy`, `done`, `hi`, `lo`.
- The `execute_stage` top contains the combinational ALU, branch logic and output registers.

## Test plan
- ADD with ALUSrc=1, `valA`=5, `imm`=-3 -> `alu_result`=2 one cycle later, `out_valid`=1, `signals_out` matches the input.
- SLT with A=32'hFFFFFFFF, B=1 -> 1; SLTU on the same operands -> 0. SRA of 32'h80000000 by 4 -> 32'hF8000000.
- MULTU 32'hFFFFFFFF × 2, then MFHI, then MFLO:
  - `in_ready` is low for exactly 32 cycles.
  - Results are HI=1 and LO=32'hFFFFFFFE.
  - The MFHI/MFLO results appear on the first accepts after `in_ready` returns high.
- DIVU 100/7 -> LO=14, HI=2. DIVU 9/0 -> LO=32'hFFFFFFFF, HI=9.
- BEQ-type input (`signals[2]`=1, `signals[1]`=1) with `valA`==`valB`, `pc_plus4`=32'h100, `imm`=4 -> `branch_taken`=1, `branch_target`=32'h110. With `valA`!=`valB` -> `branch_taken`=0.
- Reset asserted at iteration 10 of a DIVU:
  - Next cycle: all outputs 0 and `in_ready`=1.
  - HI/LO read back 0.
  - A following ADD completes normally.
